// File: rtl/wb_regfile.sv
// Writeback stage and 32 x 64-bit architectural register file. Selects the
// writeback source, byte-merges it into the destination and bypasses it to both read ports.
module wb_regfile #(
  parameter logic [0:5] LD_TYPE = 6'b100000,
  parameter int         NREG    = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [0:63] WB_ALUresult,
  input  logic [0:63] WB_MEMout,
  input  logic [0:4]  WB_Wreg,
  input  logic        WB_Wreg_en,
  input  logic [0:5]  WB_instr_type,
  input  logic [0:2]  WB_ppp,
  input  logic [0:4]  rA_addr,
  input  logic [0:4]  rB_addr,
  output logic [0:63] rA_data,
  output logic [0:63] rB_data,
  output logic [0:63] wb_data,
  output logic [0:31] wr_count
);

  logic [0:63] regs [NREG];
  logic [0:31] wr_count_q;

  logic        is_load;
  logic [0:63] src;
  logic [0:7]  mask;   // mask[k] enables big-endian byte k (bits 8k..8k+7)
  logic [0:63] cur;
  logic        do_write;

  always_comb begin
    is_load = (WB_instr_type == LD_TYPE);
    src     = is_load ? WB_MEMout : WB_ALUresult;
  end

  always_comb begin
    mask = 8'h00;
    if (is_load) begin
      mask = 8'hFF;
    end else begin
      case (WB_ppp)
        3'b000:  mask = 8'b1111_1111;
        3'b001:  mask = 8'b1111_0000;
        3'b010:  mask = 8'b0000_1111;
        3'b011:  mask = 8'b1010_1010;
        3'b100:  mask = 8'b0101_0101;
        default: mask = 8'b0000_0000;
      endcase
    end
  end

  // Merge is computed regardless of enable so wb_data is always meaningful.
  always_comb begin
    cur     = regs[WB_Wreg];
    wb_data = cur;
    for (int k = 0; k < 8; k++) begin
      if (mask[k]) begin
        wb_data[8*k +: 8] = src[8*k +: 8];
      end
    end
    do_write = WB_Wreg_en && (mask != 8'h00);
  end

  // Bypass stays active during rst; it only sees pre-reset storage.
  always_comb begin
    rA_data = (do_write && (rA_addr == WB_Wreg)) ? wb_data : regs[rA_addr];
    rB_data = (do_write && (rB_addr == WB_Wreg)) ? wb_data : regs[rB_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      wr_count_q <= '0;
    end else if (do_write) begin
      regs[WB_Wreg] <= wb_data;
      wr_count_q    <= wr_count_q + 32'd1;
    end
  end

  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: stimulus pushes expected outputs into a
// queue and a negedge monitor drains and compares them.
module tb_wb_regfile;

  localparam logic [5:0] LD  = 6'b100000;
  localparam logic [5:0] ALU = 6'b000001;
  localparam logic [63:0] C5 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  localparam int SEL_A  = 0;
  localparam int SEL_B  = 1;
  localparam int SEL_WB = 2;
  localparam int SEL_CNT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:63] WB_ALUresult;
  logic [0:63] WB_MEMout;
  logic [0:4]  WB_Wreg;
  logic        WB_Wreg_en;
  logic [0:5]  WB_instr_type;
  logic [0:2]  WB_ppp;
  logic [0:4]  rA_addr;
  logic [0:4]  rB_addr;
  logic [0:63] rA_data;
  logic [0:63] rB_data;
  logic [0:63] wb_data;
  logic [0:31] wr_count;

  always #5 clk = ~clk;

  wb_regfile #(.LD_TYPE(6'b100000), .NREG(32)) dut (
    .clk(clk), .rst(rst),
    .WB_ALUresult(WB_ALUresult), .WB_MEMout(WB_MEMout),
    .WB_Wreg(WB_Wreg), .WB_Wreg_en(WB_Wreg_en),
    .WB_instr_type(WB_instr_type), .WB_ppp(WB_ppp),
    .rA_addr(rA_addr), .rB_addr(rB_addr),
    .rA_data(rA_data), .rB_data(rB_data),
    .wb_data(wb_data), .wr_count(wr_count)
  );

  logic [63:0] exp_q[$];
  int          sel_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic expect_out(input int sel, input logic [63:0] val, input string name);
    exp_q.push_back(val);
    sel_q.push_back(sel);
    name_q.push_back(name);
  endtask

  task automatic drive(input logic r, input logic en, input logic [4:0] wreg,
                       input logic [5:0] typ, input logic [2:0] ppp,
                       input logic [63:0] alu, input logic [63:0] mem,
                       input logic [4:0] ra, input logic [4:0] rb);
    @(posedge clk);
    #1;
    rst           = r;
    WB_Wreg_en    = en;
    WB_Wreg       = wreg;
    WB_instr_type = typ;
    WB_ppp        = ppp;
    WB_ALUresult  = alu;
    WB_MEMout     = mem;
    rA_addr       = ra;
    rB_addr       = rb;
  endtask

  // Monitor: every expectation queued during a cycle is checked at its negedge.
  logic [63:0] m_exp, m_act;
  int          m_sel;
  string       m_name;
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      m_exp  = exp_q.pop_front();
      m_sel  = sel_q.pop_front();
      m_name = name_q.pop_front();
      case (m_sel)
        SEL_A:   m_act = rA_data;
        SEL_B:   m_act = rB_data;
        SEL_WB:  m_act = wb_data;
        default: m_act = {32'h0, wr_count};
      endcase
      checks++;
      if (m_act !== m_exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", m_name, m_act, m_exp);
      end
    end
  end

  initial begin
    rst = 1'b1; WB_Wreg_en = 1'b0; WB_Wreg = '0; WB_instr_type = ALU; WB_ppp = '0;
    WB_ALUresult = '0; WB_MEMout = '0; rA_addr = '0; rB_addr = '0;

    drive(1, 0, 0, ALU, 0, 0, 0, 0, 0);
    drive(1, 0, 0, ALU, 0, 0, 0, 0, 0);

    // All registers read zero after reset on both ports.
    for (int i = 0; i < 32; i++) begin
      drive(0, 0, 0, ALU, 0, 0, 0, i[4:0], 5'(31 - i));
      expect_out(SEL_A, 64'h0, $sformatf("reset_rA_%0d", i));
      expect_out(SEL_B, 64'h0, $sformatf("reset_rB_%0d", i));
    end
    expect_out(SEL_CNT, 64'd0, "reset_count");

    // Full write R5 with bypass on both ports.
    drive(0, 1, 5, ALU, 3'b000, C5, 0, 5, 5);
    expect_out(SEL_A, C5, "full_bypass_rA");
    expect_out(SEL_B, C5, "full_bypass_rB");
    expect_out(SEL_WB, C5, "full_wb_data");
    expect_out(SEL_CNT, 64'd0, "full_count_before");
    drive(0, 0, 5, ALU, 0, 0, 0, 5, 6);
    expect_out(SEL_A, C5, "full_stored");
    expect_out(SEL_B, 64'h0, "full_other_reg");
    expect_out(SEL_CNT, 64'd1, "full_count_after");

    // Lower half.
    drive(0, 1, 5, ALU, 3'b010, ONES, 0, 5, 0);
    expect_out(SEL_WB, 64'h0123_4567_FFFF_FFFF, "ppp010_wb");
    expect_out(SEL_A, 64'h0123_4567_FFFF_FFFF, "ppp010_bypass");
    drive(0, 0, 5, ALU, 0, 0, 0, 5, 0);
    expect_out(SEL_A, 64'h0123_4567_FFFF_FFFF, "ppp010_stored");
    expect_out(SEL_CNT, 64'd2, "ppp010_count");

    // Restore then even bytes.
    drive(0, 1, 5, ALU, 3'b000, C5, 0, 0, 0);
    drive(0, 1, 5, ALU, 3'b011, ONES, 0, 5, 0);
    expect_out(SEL_WB, 64'hFF23_FF67_FFAB_FFEF, "ppp011_wb");
    drive(0, 0, 5, ALU, 0, 0, 0, 5, 0);
    expect_out(SEL_A, 64'hFF23_FF67_FFAB_FFEF, "ppp011_stored");
    expect_out(SEL_CNT, 64'd4, "ppp011_count");

    // Restore then odd bytes cleared.
    drive(0, 1, 5, ALU, 3'b000, C5, 0, 0, 0);
    drive(0, 1, 5, ALU, 3'b100, 64'h0, 0, 0, 5);
    expect_out(SEL_B, 64'h0100_4500_8900_CD00, "ppp100_bypass");
    drive(0, 0, 5, ALU, 0, 0, 0, 5, 0);
    expect_out(SEL_A, 64'h0100_4500_8900_CD00, "ppp100_stored");
    expect_out(SEL_CNT, 64'd6, "ppp100_count");

    // Load ignores ppp and takes MEMout.
    drive(0, 1, 0, LD, 3'b001, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 0, 1);
    expect_out(SEL_A, 64'hDEAD_BEEF_CAFE_F00D, "load_bypass");
    expect_out(SEL_WB, 64'hDEAD_BEEF_CAFE_F00D, "load_wb");
    drive(0, 0, 0, ALU, 0, 0, 0, 0, 5);
    expect_out(SEL_A, 64'hDEAD_BEEF_CAFE_F00D, "load_stored_r0");
    expect_out(SEL_B, 64'h0100_4500_8900_CD00, "load_r5_kept");
    expect_out(SEL_CNT, 64'd7, "load_count");

    // en=0: wb_data still merges, no bypass, no commit.
    drive(0, 0, 5, ALU, 3'b000, ONES, 0, 5, 0);
    expect_out(SEL_A, 64'h0100_4500_8900_CD00, "en0_no_bypass");
    expect_out(SEL_WB, ONES, "en0_wb_data");
    drive(0, 0, 5, ALU, 0, 0, 0, 5, 0);
    expect_out(SEL_A, 64'h0100_4500_8900_CD00, "en0_unchanged");
    expect_out(SEL_CNT, 64'd7, "en0_count");

    // ppp=111 with en=1: mask 0, nothing written.
    drive(0, 1, 5, ALU, 3'b111, ONES, 0, 5, 5);
    expect_out(SEL_A, 64'h0100_4500_8900_CD00, "ppp111_no_bypass");
    expect_out(SEL_WB, 64'h0100_4500_8900_CD00, "ppp111_wb");
    drive(0, 0, 5, ALU, 0, 0, 0, 5, 0);
    expect_out(SEL_A, 64'h0100_4500_8900_CD00, "ppp111_unchanged");
    expect_out(SEL_CNT, 64'd7, "ppp111_count");

    // Back-to-back partial writes to R9 merge against the previous commit.
    drive(0, 1, 9, ALU, 3'b001, 64'h1111_1111_2222_2222, 0, 9, 0);
    expect_out(SEL_WB, 64'h1111_1111_0000_0000, "b2b_first_wb");
    drive(0, 1, 9, ALU, 3'b010, 64'h3333_3333_4444_4444, 0, 0, 9);
    expect_out(SEL_B, 64'h1111_1111_4444_4444, "b2b_second_bypass");
    drive(0, 0, 9, ALU, 0, 0, 0, 9, 0);
    expect_out(SEL_A, 64'h1111_1111_4444_4444, "b2b_stored");
    expect_out(SEL_CNT, 64'd9, "b2b_count");

    // Reset wins over a coincident write; bypass still visible during rst.
    drive(1, 1, 7, ALU, 3'b000, 64'h1, 0, 7, 7);
    expect_out(SEL_A, 64'h1, "rst_bypass_rA");
    expect_out(SEL_WB, 64'h1, "rst_wb_data");
    drive(0, 0, 7, ALU, 0, 0, 0, 7, 0);
    expect_out(SEL_A, 64'h0, "rst_r7_dropped");
    expect_out(SEL_B, 64'h0, "rst_r0_cleared");
    expect_out(SEL_CNT, 64'd0, "rst_count");
    drive(0, 0, 0, ALU, 0, 0, 0, 5, 9);
    expect_out(SEL_A, 64'h0, "rst_r5_cleared");
    expect_out(SEL_B, 64'h0, "rst_r9_cleared");

    // Counter wrap: preload all-ones, then one write.
    force dut.wr_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.wr_count_q;
    drive(0, 1, 3, ALU, 3'b000, 64'h5, 0, 3, 0);
    expect_out(SEL_A, 64'h5, "wrap_bypass");
    drive(0, 0, 3, ALU, 0, 0, 0, 3, 0);
    expect_out(SEL_CNT, 64'd0, "wrap_count");
    expect_out(SEL_A, 64'h5, "wrap_stored");

    repeat (2) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL undrained: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback stage and architectural register file of the pipelined 64-bit processor; consumes the outputs of the EXMEM/WB stage register.
- Each cycle it selects the writeback value: the load data for loads, the ALU result otherwise.
- It applies the ppp partial-write field to produce a byte-masked write into one of 32 64-bit registers.
- It provides two combinational read ports to the ID stage, with write-through bypass so a same-cycle read sees the value being written.

Parameters:
- LD_TYPE, 6'b100000, instr_type encoding that selects WB_MEMout as the writeback source.
- NREG, 32, number of registers (address width fixed at 5).

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- WB_ALUresult  input  [0:63]  ALU result from the EXMEM/WB register
- WB_MEMout  input  [0:63]  load data from the EXMEM/WB register
- WB_Wreg  input  [0:4]  destination register address
- WB_Wreg_en  input  1  write enable
- WB_instr_type  input  [0:5]  instruction type; compared against LD_TYPE
- WB_ppp  input  [0:2]  partial-write field
- rA_addr  input  [0:4]  read port A address
- rB_addr  input  [0:4]  read port B address
- rA_data  output  [0:63]  read port A data (combinational, bypassed)
- rB_data  output  [0:63]  read port B data (combinational, bypassed)
- wb_data  output  [0:63]  merged value committed this cycle (debug/forwarding)
- wr_count  output  [0:31]  count of committed writes (debug)

Behaviour:
- Bit numbering is big-endian: bit 0 is the MSB. Byte k occupies bits [8k:8k+7], k = 0..7.
- Source select: src = (WB_instr_type == LD_TYPE) ? WB_MEMout : WB_ALUresult.
- Byte mask from ppp, used when the instruction is not a load:
  - 000: all bytes, mask 8'b1111_1111.
  - 001: upper half, bytes 0-3, mask 8'b1111_0000.
  - 010: lower half, bytes 4-7, mask 8'b0000_1111.
  - 011: even bytes 0,2,4,6, mask 8'b1010_1010.
  - 100: odd bytes 1,3,5,7, mask 8'b0101_0101.
  - 101-111: mask 0; no bytes written and wr_count does not increment.
- Loads (instr_type == LD_TYPE) always use mask 8'hFF; ppp is ignored.
- Merge: wb_data byte k = mask[k] ? src byte k : current regs[WB_Wreg] byte k. wb_data is combinational and is valid even when WB_Wreg_en = 0.
- Commit on posedge clk:
  - If !rst and WB_Wreg_en and mask != 0: regs[WB_Wreg] <= wb_data and wr_count <= wr_count + 1.
  - wr_count wraps 2^32-1 -> 0.
- R0 is an ordinary writable register; it is not hardwired to zero.
- Read ports:
  - rX_data = (WB_Wreg_en && mask != 0 && rX_addr == WB_Wreg) ? wb_data : regs[rX_addr].
  - The bypass gives write-then-read semantics in the same cycle.
  - Both ports may read the same address, including the write address, simultaneously.
- Latency:
  - Write visible on the read ports combinationally in the commit cycle via bypass.
  - Write visible from storage from the next cycle on.
- Reset:
  - On posedge clk with rst = 1, all NREG registers <= 0 and wr_count <= 0.
  - Reset takes priority over a simultaneous write; the write is dropped.
  - During rst, read ports still apply the bypass combinationally. Bypass data merges with pre-reset register contents.
  - Storage is all-zero from the first cycle after reset.
- Reset values of outputs (after the reset edge, no write pending):
  - rA_data = rB_data = 0.
  - wb_data = masked src merged with 0.
  - wr_count = 0.
- No stall or handshake: one writeback per cycle. Back-to-back writes to the same register each merge against the value committed the previous cycle.

Test Plan:
- Reset, then read all 32 addresses on both ports -> every rA_data/rB_data = 0; wr_count = 0.
- Full write: Wreg=5, en=1, type=ALU, ppp=000, ALUresult=64'h0123_4567_89AB_CDEF -> same cycle rA_addr=5 reads 64'h0123_4567_89AB_CDEF (bypass); next cycle storage holds it; wr_count=1.
- Partial writes on R5 = 64'h0123_4567_89AB_CDEF (each scenario starts from this value):
  - ppp=010, ALUresult=64'hFFFF_FFFF_FFFF_FFFF -> R5=64'h0123_4567_FFFF_FFFF.
  - ppp=011, ALUresult=64'hFFFF_FFFF_FFFF_FFFF -> R5=64'hFF23_FF67_FFAB_FFEF.
  - ppp=100, ALUresult=64'h0 -> R5=64'h0100_4500_8900_CD00.
- Load select: type=LD_TYPE, ppp=001, MEMout=64'hDEAD_BEEF_CAFE_F00D, ALUresult=0, Wreg=0 -> R0=64'hDEAD_BEEF_CAFE_F00D (full write, ppp ignored).
- No-write cases: en=0 with any data -> storage unchanged, wr_count unchanged. ppp=111 with en=1 -> unchanged, no bypass, wr_count unchanged.
- Reset mid-operation: rst=1 coincident with en=1, Wreg=7, data=64'h1 -> R7=0 next cycle, wr_count=0. Then 2^32 writes (or wr_count forced to 32'hFFFF_FFFF) plus one write -> wr_count=0.
